// File: rtl/fir_sample_source.sv
// fir_sample_source: plays samples from a small writable memory into a FIR
// input port, with programmable length, inter-sample gap and a drain period
// before signalling end of simulation.
// Optional feature macro: SRC_REPEAT_EN adds input 'rep', which loops the
// stream back to index 0 instead of draining.
// DEPTH is expected to be a power of two so every wr_addr value is a valid entry.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_IDLE  | waiting for start after reset; memory writable
// ST_SEND  | presenting mem[idx] with vout=1 for one cycle
// ST_GAP   | idle cycles after a sample (latched gap count)
// ST_DRAIN | DRAIN idle cycles after the last sample
// ST_DONE  | stream complete, end_sim=1; memory writable, start accepted
module fir_sample_source #(
    parameter int NB    = 14,
    parameter int DEPTH = 64,
    parameter int DRAIN = 16,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [NB-1:0] wr_data,
    input  logic [AW:0]   len,
    input  logic [3:0]    gap,
    input  logic          start,
`ifdef SRC_REPEAT_EN
    input  logic          rep,
`endif
    output logic [NB-1:0] dout,
    output logic          vout,
    output logic          busy,
    output logic          end_sim
);

    // Counter must hold both DRAIN-1 and the largest gap load (14).
    localparam int CW = (DRAIN > 16) ? $clog2(DRAIN) : 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SEND,
        ST_GAP,
        ST_DRAIN,
        ST_DONE
    } state_t;

    // With no drain period the last sample leads straight to DONE.
    localparam state_t DRAIN_ENTRY = (DRAIN == 0) ? ST_DONE : ST_DRAIN;
    localparam logic [CW-1:0] DRAIN_LOAD = CW'(DRAIN - 1);

    logic [NB-1:0] mem [DEPTH];

    state_t        state, state_n;
    logic [AW-1:0] idx, idx_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [AW:0]   len_q, len_n;
    logic [3:0]    gap_q, gap_n;

    logic          rep_i;
    logic          wr_ok;
    logic          is_last;
    logic          sample_done;
    logic [AW:0]   len_clamped;
    logic [NB-1:0] rd_data;

`ifdef SRC_REPEAT_EN
    assign rep_i = rep;
`else
    assign rep_i = 1'b0;
`endif

    // The memory is only writable while no stream is running.
    assign wr_ok       = wr_en && (state == ST_IDLE || state == ST_DONE);
    assign len_clamped = (len > (AW+1)'(DEPTH)) ? (AW+1)'(DEPTH) : len;
    assign is_last     = ({1'b0, idx} == (len_q - (AW+1)'(1)));
    assign sample_done = (state == ST_SEND && gap_q == 4'd0) ||
                         (state == ST_GAP && cnt == '0);

    // Sample memory: written only when idle; contents survive rst.
    always_ff @(posedge clk) begin
        if (!rst && wr_ok) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Next-state logic: launch, per-sample gap, advance/loop, drain countdown.
    always_comb begin
        state_n = state;
        idx_n   = idx;
        cnt_n   = cnt;
        len_n   = len_q;
        gap_n   = gap_q;
        case (state)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    idx_n = '0;
                    gap_n = gap;
                    len_n = len_clamped;
                    if (len != '0) begin
                        state_n = ST_SEND;
                    end else begin
                        state_n = DRAIN_ENTRY;
                        cnt_n   = DRAIN_LOAD;
                    end
                end
            end
            ST_SEND: begin
                if (gap_q != 4'd0) begin
                    state_n = ST_GAP;
                    cnt_n   = CW'(gap_q) - CW'(1);
                end
            end
            ST_GAP: begin
                if (cnt != '0) begin
                    cnt_n = cnt - CW'(1);
                end
            end
            ST_DRAIN: begin
                if (cnt == '0) begin
                    state_n = ST_DONE;
                end else begin
                    cnt_n = cnt - CW'(1);
                end
            end
            default: state_n = ST_IDLE;
        endcase

        // End of a sample slot: next sample, loop back, or drain.
        if (sample_done) begin
            if (!is_last) begin
                state_n = ST_SEND;
                idx_n   = idx + AW'(1);
            end else if (rep_i) begin
                state_n = ST_SEND;
                idx_n   = '0;
            end else begin
                state_n = DRAIN_ENTRY;
                cnt_n   = DRAIN_LOAD;
            end
        end
    end

    // A write in the launch cycle must be visible to the first sample.
    always_comb begin
        rd_data = mem[idx_n];
        if (wr_ok && wr_addr == idx_n) begin
            rd_data = wr_data;
        end
    end

    // State register and registered outputs, decoded from the next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            idx     <= '0;
            cnt     <= '0;
            len_q   <= '0;
            gap_q   <= '0;
            dout    <= '0;
            vout    <= 1'b0;
            busy    <= 1'b0;
            end_sim <= 1'b0;
        end else begin
            state   <= state_n;
            idx     <= idx_n;
            cnt     <= cnt_n;
            len_q   <= len_n;
            gap_q   <= gap_n;
            vout    <= (state_n == ST_SEND);
            dout    <= (state_n == ST_SEND) ? rd_data : '0;
            busy    <= (state_n == ST_SEND) || (state_n == ST_GAP) ||
                       (state_n == ST_DRAIN);
            end_sim <= (state_n == ST_DONE);
        end
    end

endmodule

// File: doc/fir_sample_source.md
FIR_SAMPLE_SOURCE -- requirements
Module: fir_sample_source

Interface
REQ-001 Parameter NB, default 14: sample width in bits, matching the FIR data and coefficient width.
REQ-002 Parameter DEPTH, default 64: sample memory entries; AW = log2(DEPTH) = 6.
REQ-003 Parameter DRAIN, default 16: idle cycles after the last sample before end_sim rises.
REQ-004 clk  in  1  single clock; all logic on rising edge.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 wr_en  in  1  memory write strobe.
REQ-007 wr_addr  in  AW  memory write address.
REQ-008 wr_data  in  NB  memory write data, two's complement.
REQ-009 len  in  AW+1  samples per stream; 0 means empty; values above DEPTH are clamped to DEPTH.
REQ-010 gap  in  4  idle cycles inserted after each sample (0 to 15).
REQ-011 start  in  1  one-cycle stream launch request.
REQ-012 dout  out  NB  sample to the FIR din port.
REQ-013 vout  out  1  sample valid to the FIR vin port.
REQ-014 busy  out  1  high while a stream or its drain is in progress.
REQ-015 end_sim  out  1  stream complete; high in DONE.

Function
REQ-016 The FSM SHALL have states IDLE, SEND, GAP, DRAIN and DONE; all outputs SHALL be registered.
REQ-017 In IDLE or DONE, start=1 with len!=0 SHALL latch min(len, DEPTH) and gap, clear the index to 0, and enter SEND on the next edge.
REQ-018 start=1 with len=0 SHALL go directly to DRAIN, so no vout pulse is issued.
REQ-019 In SEND, vout SHALL be 1 and dout SHALL equal mem[index] for exactly one cycle; the index then increments.
REQ-020 After SEND, the FSM SHALL enter GAP for the latched gap count of cycles with vout=0; gap=0 SHALL give back-to-back SEND cycles.
REQ-021 After the SEND cycle that carries the last sample, plus its GAP, the FSM SHALL enter DRAIN for DRAIN cycles, then DONE.
REQ-022 dout SHALL be 0 whenever vout=0.
REQ-023 busy SHALL be 1 in SEND, GAP and DRAIN, and 0 in IDLE and DONE.
REQ-024 end_sim SHALL be 1 only in DONE, and SHALL stay 1 until rst or a new accepted start.
REQ-025 start while busy=1 SHALL be ignored.
REQ-026 wr_en while busy=1 SHALL be ignored, so memory contents are stable during a stream.
REQ-027 wr_en while busy=0 SHALL write the memory in that cycle; a start in the same cycle SHALL see the new data.
REQ-028 The first vout SHALL rise exactly 1 cycle after the accepted start.
REQ-029 For a stream of L samples, total stream length from the accepted start to end_sim=1 SHALL be L*(gap+1)+DRAIN+1 cycles.
REQ-030 The index SHALL never exceed DEPTH-1, with no wrap-around within one pass.

Reset
REQ-031 rst=1 SHALL force state IDLE, index 0, vout=0, dout=0, busy=0 and end_sim=0 on the next edge, including mid-stream.
REQ-032 Memory contents SHALL NOT be cleared by rst.
REQ-033 rst SHALL have priority over start and wr_en.

Configuration
REQ-034 With macro SRC_REPEAT_EN defined, input port rep (1 bit) SHALL exist; if rep=1 when the last sample's GAP ends, the FSM SHALL return to SEND with index 0 instead of entering DRAIN.
REQ-035 With SRC_REPEAT_EN undefined, port rep SHALL be absent and every stream SHALL be a single pass.

Verification
REQ-036 Load mem[0..3]=1,-2,3,-4; len=4, gap=0, start -> vout high for 4 consecutive cycles starting 1 cycle after start, dout=1,-2,3,-4; end_sim rises 21 cycles after start.
REQ-037 Same data, gap=2 -> vout pattern 100100100100, dout=0 in gap cycles; end_sim rises 29 cycles after start.
REQ-038 len=0, start -> no vout pulse; busy high for 16 cycles; end_sim rises 17 cycles after start.
REQ-039 len=100 -> exactly 64 samples sent; wr_en to mem[0] mid-stream -> mem[0] unchanged on the next stream.
REQ-040 rst asserted on the 3rd sample -> all outputs 0 next cycle; a new start replays the stream from mem[0].
REQ-041 SRC_REPEAT_EN defined, rep=1, len=2, gap=0 -> dout alternates mem[0],mem[1] continuously; deassert rep -> drain, then end_sim.
